// File: rtl/alu_status_tx.sv
// UART-style serial transmitter for the ALU status byte {Zero, Carry, Sign, Error, Result[3:0]}.
// One-entry holding buffer behind a valid/ready handshake; registered, glitch-free tx/busy.
module alu_status_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_count
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        buf_q, buf_d;
  logic              full_q, full_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [7:0]        count_q, count_d;
  logic              baud_last;
  logic              load;

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // bit_q indexes data bits in DATA and stop bits in STOP.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    buf_d   = buf_q;
    count_d = count_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (full_q) load = 1'b1;
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      PARITY: begin
        if (baud_last) begin
          state_d = STOP;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            count_d = count_q + 8'd1;
            if (full_q) load = 1'b1;
            else        state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = START;
      data_d  = buf_q;
      baud_d  = '0;
      bit_d   = 3'd0;
    end

    // The load empties the buffer before a new accept can refill it.
    full_d = full_q & ~load;
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      buf_d  = in_data;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      PARITY:  tx_d = ^data_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      buf_q   <= 8'd0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign in_ready    = ~full_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frame_count = count_q;

endmodule
